// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplies in muldiv_unit).
package muldiv_pkg;

    // M-extension funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } muldiv_state_e;

    localparam logic [31:0] MULDIV_DIV0_Q  = '1;
    localparam logic [31:0] MULDIV_INT_MIN = 32'h8000_0000;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic op_b_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_iter_div.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// The quotient register starts out holding the dividend and shifts it out MSB first.
module muldiv_iter_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quot_o,
    output logic [DATA_WIDTH-1:0] rem_o
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0] quot_q, rem_q, dvsr_q;
    logic [W:0]   shifted;
    logic [W-1:0] diff;
    logic         fits;

    // Partial remainder gains the next dividend bit; the trial subtract only needs W bits
    // because it is kept only when the result is below the divisor.
    assign shifted = {rem_q, quot_q[W-1]};
    assign fits    = (shifted >= {1'b0, dvsr_q});
    assign diff    = shifted[W-1:0] - dvsr_q;

    // Load magnitudes, then shift in one quotient bit per step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else if (load_i) begin
            quot_q <= dividend_i;
            rem_q  <= '0;
            dvsr_q <= divisor_i;
        end else if (step_i) begin
            rem_q  <= fits ? diff : shifted[W-1:0];
            quot_q <= {quot_q[W-2:0], fits};
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// FSM IDLE -> PREP -> CALC -> FIN; divide-by-zero and signed overflow skip CALC.
// Build macro MULDIV_FAST_MUL_EN: multiplies use one 33x33 signed product, IDLE -> FIN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     flush,
    input  logic [OPCODE_LENGTH-1:0] Funct3,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    muldiv_state_e  state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic [W-1:0]   result_q, result_d;

    muldiv_op_e     op_q;
    logic [W-1:0]   a_q, b_q;
    logic           neg_q, rem_neg_q;
    logic [W-1:0]   mcand_q;
    logic [2*W-1:0] prod_q;

    logic           accept;
    logic           is_div, a_neg, b_neg, div0, ovf, special;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] prod_fix, prod_sel;
    logic [W-1:0]   quot, rem, quot_fix, rem_fix;
    logic [W-1:0]   fin_res;

    // flush wins over start, so a flushed cycle never accepts a new request
    assign accept = (state_q == IDLE) && start && !flush;

    // Operand decode from the latched request
    assign is_div  = op_is_div(op_q);
    assign a_neg   = op_a_signed(op_q) & a_q[W-1];
    assign b_neg   = op_b_signed(op_q) & b_q[W-1];
    assign a_mag   = a_neg ? -a_q : a_q;
    assign b_mag   = b_neg ? -b_q : b_q;
    assign div0    = is_div && (b_q == '0);
    // Signed divides have funct3[0]=0 (DIV, REM)
    assign ovf     = is_div && !op_q[0] && (a_q == W'(MULDIV_INT_MIN)) && (b_q == '1);
    assign special = div0 || ovf;

    // Shift-add: low half of prod_q starts as the multiplier and drains out LSB first
    assign mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

    muldiv_iter_div #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .load_i     (state_q == PREP),
        .step_i     (state_q == CALC),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    // Sign fix-up: quotient/product carry the XOR of operand signs, remainder the dividend sign
    assign prod_fix = neg_q ? -prod_q : prod_q;
    assign quot_fix = neg_q ? -quot : quot;
    assign rem_fix  = rem_neg_q ? -rem : rem;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [W:0]     a_ext, b_ext;
    logic signed [2*W-1:0] fast_prod;
    assign a_ext     = {op_a_signed(op_q) & a_q[W-1], a_q};
    assign b_ext     = {op_b_signed(op_q) & b_q[W-1], b_q};
    assign fast_prod = (2*W)'(a_ext * b_ext);
    assign prod_sel  = fast_prod;
`else
    assign prod_sel  = prod_fix;
`endif

    // Final result selection, including the div-by-zero and overflow encodings
    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_MUL:                       fin_res = prod_sel[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_sel[2*W-1:W];
            OP_DIV, OP_DIVU:              fin_res = div0 ? W'(MULDIV_DIV0_Q) :
                                                    ovf  ? W'(MULDIV_INT_MIN) : quot_fix;
            OP_REM, OP_REMU:              fin_res = div0 ? a_q : ovf ? '0 : rem_fix;
            default:                      fin_res = '0;
        endcase
    end

    // Next-state, counter, done pulse and result register update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_d = op_is_div(muldiv_op_e'(Funct3)) ? PREP : FIN;
`else
                    state_d = PREP;
`endif
                end
            end
            PREP: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (special) begin
                    state_d = FIN;
                end else begin
                    state_d = CALC;
                    cnt_d   = CW'(W - 1);
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!flush) begin
                    result_d = fin_res;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Operand latch on accept, magnitude/sign capture in PREP, multiply step in CALC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
        end else begin
            if (accept) begin
                op_q <= muldiv_op_e'(Funct3);
                a_q  <= SrcA;
                b_q  <= SrcB;
            end
            if (state_q == PREP) begin
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                mcand_q   <= a_mag;
                prod_q    <= {{W{1'b0}}, b_mag};
            end else if (state_q == CALC) begin
                prod_q <= {mul_sum, prod_q[W-1:1]};
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues the expected result and the
// cycle at which done must appear; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] Result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    muldiv_unit #(
        .DATA_WIDTH    (32),
        .OPCODE_LENGTH (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    always #5 clk = ~clk;

    // Monitor: counts cycles and checks each done pulse against the queue head
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: Result=%h at cycle %0d, required no done", Result, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (Result !== e.res || cyc != e.cyc) begin
                        fails++;
                        $display("FAIL %s: Result=%h at cycle %0d, required Result=%h at cycle %0d",
                                 e.name, Result, cyc, e.res, e.cyc);
                    end
                end
            end
        end
    end

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 32'h0) return 3;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
            return 35;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return 35;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    // Called at a negedge: present a request for one cycle, optionally queue its expectation
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input bit push, input string nm);
        exp_t e;
        start  = 1'b1;
        Funct3 = op;
        SrcA   = a;
        SrcB   = b;
        if (push) begin
            e.res  = want;
            e.cyc  = cyc + lat_of(op, a, b);
            e.name = nm;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain
    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input string nm);
        @(negedge clk);
        send(op, a, b, want, 1'b1, nm);
        wait_idle();
    endtask

    initial begin
        int n;
        reset  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, busy}, 32'h0);
        check("reset_done",   {31'b0, done}, 32'h0);
        check("reset_result", Result,        32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'h0);

        // Directed vectors: funct3, rs1, rs2, hand-computed result
        run(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
        run(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulhu_min_min");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
        run(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_shift4");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1");
        run(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "mulhu_max_2");
        run(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7_2");
        run(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7_2");
        run(3'b101, 32'd100,       32'd7,         32'd14,        "divu_100_7");
        run(3'b111, 32'd100,       32'd7,         32'd2,         "remu_100_7");
        run(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_-2");
        run(3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, "rem_7_-2");
        run(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, "divu_max_1");
        run(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, "div_5_0");
        run(3'b111, 32'd5,         32'd0,         32'd5,         "remu_5_0");
        run(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0");
        run(3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, "rem_-5_0");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        // A start while busy must be ignored: no queueing, operands untouched
        @(negedge clk);
        send(3'b101, 32'd100, 32'd7, 32'd14, 1'b1, "busy_ignore");
        repeat (4) @(negedge clk);
        check("busy_during_op", {31'b0, busy}, 32'h1);
        start = 1'b1; Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd3;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // Flush during CALC: back to IDLE, no done, Result kept
        @(negedge clk);
        send(3'b111, 32'd100, 32'd7, 32'd0, 1'b0, "flushed");
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #2;
        check("flush_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);
        check("flush_result_kept", Result, 32'd14);

        // flush and start together in IDLE: start is dropped
        start = 1'b1; flush = 1'b1; Funct3 = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
        @(posedge clk);
        #2;
        check("flush_over_start", {31'b0, busy}, 32'h0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;

        // Reset mid-CALC clears outputs immediately
        @(negedge clk);
        send(3'b101, 32'd1000, 32'd3, 32'd0, 1'b0, "reset_abort");
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy",   {31'b0, busy}, 32'h0);
        check("midrst_done",   {31'b0, done}, 32'h0);
        check("midrst_result", Result,        32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        // Back-to-back: a start in the done cycle is accepted
        @(negedge clk);
        send(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, "b2b_div");
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("b2b_done_seen1", {31'b0, done}, 32'h1);
        send(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, "b2b_rem");
        n = 0;
        while (!done && n < 100) begin @(negedge clk); n++; end
        check("b2b_done_seen2", {31'b0, done}, 32'h1);
        send(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "b2b_div0");
        wait_idle();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
